load_hazard_scoreboard: RTL and testbench
=========================================

Name: load_hazard_scoreboard

Overview:
Producer-side counterpart to the EX operand forwarding logic. It tracks in-flight load destinations that cannot yet be forwarded, and stalls the front end when a decoding instruction reads such a register. It also handles multi-cycle data-memory waits and branch flushes. It sits beside the ID stage and drives the PC/IF-ID enables and the ID/EX bubble insert.

Parameters:
NREGS, 32, architectural register count (x0 hardwired zero)
AW, 5, register address width, log2(NREGS)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  AW  ID source register 1
id_rs2  in  AW  ID source register 2
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  AW  ID destination register
id_regwrite  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_busy  in  1  data memory has not completed the current access
wb_regwrite  in  1  WB stage writes the register file this cycle
wb_rd  in  AW  WB destination register
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID register
bubble_idex  out  1  load NOP into ID/EX
flush_ifid  out  1  clear IF/ID (wrong-path instruction)
pending_mask  out  NREGS  bit r set = load to r in flight
stall_count  out  CNT_W  total stall cycles, saturating

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: pending_mask=0, stall_count=0, state=RUN, all control outputs 0.
- Issue event: `id_valid && !stall_ifid && !flush_ifid`.
- Set: on issue with `id_is_load && id_regwrite && id_rd!=0`, set pending_mask[id_rd] at the next edge.
- Clear: when `wb_regwrite && wb_rd!=0`, clear pending_mask[wb_rd] at the next edge.
- Set and clear on the same register in the same cycle: set wins (newer load).
- Bit 0 is never set.
- Load-use hazard (combinational): id_valid and either of:
  - id_uses_rs1 with pending_mask[id_rs1], excluding the case `wb_regwrite && wb_rd==id_rs1`;
  - the same test for rs2.
  A register being written back this cycle is forwardable and does not stall.
- FSM state RUN: outputs idle unless a condition below applies.
- RUN, hazard: `stall_pc=stall_ifid=bubble_idex=1` in the same cycle. Go to HAZ_STALL.
- RUN, mem_busy: `stall_pc=stall_ifid=1`, bubble_idex=0 (the whole pipe freezes). Go to MEM_WAIT.
- FSM state HAZ_STALL: same outputs as RUN-hazard while the hazard persists. Return to RUN in the cycle the hazard drops; no extra bubble.
- FSM state MEM_WAIT: hold the stalls while mem_busy. On the first cycle with mem_busy=0, return to RUN and re-evaluate the hazard that same cycle.
- Priority: flush > mem_busy > hazard.
- ex_branch_taken (any state): flush_ifid=1 and bubble_idex=1 for that cycle, stall_pc=0, and no set event. Next state is RUN, unless mem_busy is also high, in which case the next state is MEM_WAIT.
- Flush does not touch pending_mask; older loads still complete.
- stall_count: +1 on every cycle with stall_pc=1; holds at all-ones.
- rst mid-stall: everything returns to reset values on the next edge.
- Outputs are combinational from state, pending_mask and inputs. pending_mask and stall_count are registered.
- Zero added latency: a hazard causes a stall in the same cycle the instruction sits in ID.

Decomposition:
- Shared package `hazard_pkg`:
  - typedef enum hz_state_t {RUN, HAZ_STALL, MEM_WAIT};
  - typedef logic [AW-1:0] reg_addr_t;
  - constant REG_ZERO = '0.
- Sub-module `reg_scoreboard`: NREGS-bit set/clear array with x0 masking and set-over-clear priority.
- The top block holds the FSM, hazard compare and counter.

Test Plan:
1. Load-use stall: issue `lw x5` then `add x6,x5,x1` → exactly 1 cycle of stall_pc=stall_ifid=bubble_idex=1. pending_mask[5] clears when wb_rd=5; stall_count=1.
2. Load with an independent use: `lw x5` then `add x7,x2,x3` → no stall; pending_mask=0x20 until WB.
3. WB bypass: pending_mask[9]=1, wb_regwrite=1, wb_rd=9, ID reads x9 → no stall that cycle.
4. x0 destination: `lw x0` followed by a use of x0 → pending_mask stays 0, no stall.
5. Memory wait: mem_busy high for 3 cycles during RUN → stall_pc high for 3 cycles, bubble_idex=0, stall_count +3, then RUN.
6. Flush during hazard: ex_branch_taken=1 while in HAZ_STALL → flush_ifid=1, bubble_idex=1, stall_pc=0, next state RUN, pending bit retained.
7. Reset during MEM_WAIT: rst=1 for one cycle → all outputs 0, state RUN, stall_count 0.

Source files
------------

// File: rtl/load_hazard_scoreboard_pkg.sv
// Shared types and sizing for the load-use hazard scoreboard.
package hazard_pkg;

  localparam int NREGS = 32;  // architectural registers, x0 hardwired zero
  localparam int AW    = 5;   // log2(NREGS)
  localparam int CNT_W = 16;  // saturating stall-cycle counter width

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HAZ_STALL = 2'd1,
    MEM_WAIT  = 2'd2
  } hz_state_t;

  typedef logic [AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/load_hazard_scoreboard_if.sv
// Pipeline-side signal bundle: ID/EX/MEM/WB observations in, stall/flush controls out.
interface load_hazard_scoreboard_if;
  import hazard_pkg::*;

  logic                  id_valid;
  reg_addr_t             id_rs1;
  reg_addr_t             id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  reg_addr_t             id_rd;
  logic                  id_regwrite;
  logic                  id_is_load;
  logic                  ex_branch_taken;
  logic                  mem_busy;
  logic                  wb_regwrite;
  reg_addr_t             wb_rd;
  logic                  stall_pc;
  logic                  stall_ifid;
  logic                  bubble_idex;
  logic                  flush_ifid;
  logic [NREGS-1:0]      pending_mask;
  logic [CNT_W-1:0]      stall_count;

  // Pipeline side: drives stage information, receives controls.
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regwrite, id_is_load, ex_branch_taken, mem_busy,
           wb_regwrite, wb_rd,
    input  stall_pc, stall_ifid, bubble_idex, flush_ifid, pending_mask,
           stall_count
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regwrite, id_is_load, ex_branch_taken, mem_busy,
           wb_regwrite, wb_rd,
    output stall_pc, stall_ifid, bubble_idex, flush_ifid, pending_mask,
           stall_count
  );

endinterface

// File: rtl/load_hazard_scoreboard_scoreboard.sv
// Per-register pending-load bits: set by an issuing load, cleared by
// write-back. A same-cycle set beats a clear because the set belongs to a
// newer load. Bit 0 never holds state.
module reg_scoreboard
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  reg_addr_t        set_addr,
  input  logic             clr_en,
  input  reg_addr_t        clr_addr,
  output logic [NREGS-1:0] mask
);

  logic [NREGS-1:0] mask_reg;
  logic [NREGS-1:0] mask_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign mask_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit = set_en && (set_addr == AW'(gi));
        assign clr_hit = clr_en && (clr_addr == AW'(gi));
        assign mask_next[gi] = set_hit | (mask_reg[gi] & ~clr_hit);
      end
    end
  endgenerate

  // Register the whole mask; synchronous clear on reset.
  always_ff @(posedge clk) begin
    if (rst) mask_reg <= '0;
    else     mask_reg <= mask_next;
  end

  assign mask = mask_reg;

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard scoreboard: stalls the front end while ID reads a register
// whose load has not reached write-back, freezes on data-memory waits, and
// flushes IF/ID on a taken branch. All controls are combinational so a hazard
// stalls in the same cycle the consumer sits in ID.
module load_hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  load_hazard_scoreboard_if.slave bus
);

  hz_state_t        state_reg;
  hz_state_t        state_next;
  logic [CNT_W-1:0] stall_count_reg;
  logic [NREGS-1:0] pending;
  logic             hazard;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             issue;
  logic             set_en;
  logic             clr_en;
  logic             stall_pc_c;
  logic             bubble_c;
  logic             flush_c;

  // A register being written back this cycle is forwardable, so it does not stall.
  always_comb begin
    rs1_hit = bus.id_uses_rs1 && pending[bus.id_rs1] &&
              !(bus.wb_regwrite && (bus.wb_rd == bus.id_rs1));
    rs2_hit = bus.id_uses_rs2 && pending[bus.id_rs2] &&
              !(bus.wb_regwrite && (bus.wb_rd == bus.id_rs2));
    hazard  = bus.id_valid && (rs1_hit || rs2_hit);
  end

  // Next state and controls; flush beats memory wait beats hazard.
  always_comb begin
    state_next = state_reg;
    stall_pc_c = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    if (bus.ex_branch_taken) begin
      flush_c    = 1'b1;
      bubble_c   = 1'b1;
      state_next = bus.mem_busy ? MEM_WAIT : RUN;
    end else begin
      case (state_reg)
        MEM_WAIT: begin
          if (bus.mem_busy) begin
            stall_pc_c = 1'b1;
          end else if (hazard) begin
            // Leaving the wait re-evaluates the hazard in the same cycle.
            stall_pc_c = 1'b1;
            bubble_c   = 1'b1;
            state_next = HAZ_STALL;
          end else begin
            state_next = RUN;
          end
        end
        default: begin  // RUN and HAZ_STALL
          if (bus.mem_busy) begin
            stall_pc_c = 1'b1;
            state_next = MEM_WAIT;
          end else if (hazard) begin
            stall_pc_c = 1'b1;
            bubble_c   = 1'b1;
            state_next = HAZ_STALL;
          end else begin
            state_next = RUN;
          end
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk) begin
    if (rst)
      stall_count_reg <= '0;
    else if (stall_pc_c && (stall_count_reg != {CNT_W{1'b1}}))
      stall_count_reg <= stall_count_reg + 1'b1;
  end

  assign issue  = bus.id_valid && !stall_pc_c && !flush_c;
  assign set_en = issue && bus.id_is_load && bus.id_regwrite &&
                  (bus.id_rd != REG_ZERO);
  assign clr_en = bus.wb_regwrite && (bus.wb_rd != REG_ZERO);

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_addr (bus.id_rd),
    .clr_en   (clr_en),
    .clr_addr (bus.wb_rd),
    .mask     (pending)
  );

  assign bus.stall_pc     = stall_pc_c;
  assign bus.stall_ifid   = stall_pc_c;
  assign bus.bubble_idex  = bubble_c;
  assign bus.flush_ifid   = flush_c;
  assign bus.pending_mask = pending;
  assign bus.stall_count  = stall_count_reg;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences, randomized traffic against a rule-level model, and counter
// saturation.
module tb_load_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_hazard_scoreboard_if bus ();

  load_hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       br;
    logic       busy;
    logic       wbw;
    logic [4:0] wbrd;
    logic       e_spc;
    logic       e_bub;
    logic       e_fl;
    logic [31:0] e_mask;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic [4:0] rd, logic rw,
                              logic ld, logic br, logic busy, logic wbw,
                              logic [4:0] wbrd, logic spc, logic bub,
                              logic fl, logic [31:0] m, logic [15:0] c);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
    r.rw = rw; r.ld = ld; r.br = br; r.busy = busy; r.wbw = wbw;
    r.wbrd = wbrd; r.e_spc = spc; r.e_bub = bub; r.e_fl = fl;
    r.e_mask = m; r.e_cnt = c;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    bus.id_valid        = x.v;
    bus.id_rs1          = x.rs1;
    bus.id_rs2          = x.rs2;
    bus.id_uses_rs1     = x.u1;
    bus.id_uses_rs2     = x.u2;
    bus.id_rd           = x.rd;
    bus.id_regwrite     = x.rw;
    bus.id_is_load      = x.ld;
    bus.ex_branch_taken = x.br;
    bus.mem_busy        = x.busy;
    bus.wb_regwrite     = x.wbw;
    bus.wb_rd           = x.wbrd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Check every output of the block against one expectation set.
  task automatic chk_all(input string tag, input logic spc, input logic bub,
                         input logic fl, input logic [31:0] m,
                         input logic [15:0] c);
    chk({tag, ".stall_pc"},     32'(bus.stall_pc),     32'(spc));
    chk({tag, ".stall_ifid"},   32'(bus.stall_ifid),   32'(spc));
    chk({tag, ".bubble_idex"},  32'(bus.bubble_idex),  32'(bub));
    chk({tag, ".flush_ifid"},   32'(bus.flush_ifid),   32'(fl));
    chk({tag, ".pending_mask"}, bus.pending_mask,      m);
    chk({tag, ".stall_count"},  32'(bus.stall_count),  32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t idle();
    return mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive(idle());
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Behavioural model state: one pending flag per register, stall tally.
  logic [31:0] m_pend;
  int          m_cnt;

  task automatic model_step(input vec_t x, output logic spc, output logic bub,
                            output logic fl);
    logic haz;
    logic issue;
    haz = x.v && ((x.u1 && m_pend[x.rs1] && !(x.wbw && x.wbrd == x.rs1)) ||
                  (x.u2 && m_pend[x.rs2] && !(x.wbw && x.wbrd == x.rs2)));
    fl    = x.br;
    spc   = !x.br && (x.busy || haz);
    bub   = x.br || (!x.busy && haz);
    issue = x.v && !spc && !x.br;
    if (x.wbw && x.wbrd != 0) m_pend[x.wbrd] = 1'b0;
    if (issue && x.ld && x.rw && x.rd != 0) m_pend[x.rd] = 1'b1;
    if (spc && m_cnt < 65535) m_cnt++;
  endtask

  initial begin
    vec_t x;
    logic spc, bub, fl;
    logic [31:0] pend_before;
    int   cnt_before;

    //            v rs1 rs2 u1 u2 rd rw ld br by wbw wbrd  spc bub fl mask       cnt
    vecs[0]  = mk(1, 1, 0, 1,0, 5, 1,1, 0,0, 0, 0,   0,0,0, 32'h0,      0); // lw x5
    vecs[1]  = mk(1, 5, 1, 1,1, 6, 1,0, 0,0, 0, 0,   1,1,0, 32'h20,     0); // add x6,x5,x1
    vecs[2]  = mk(1, 5, 1, 1,1, 6, 1,0, 0,0, 1, 5,   0,0,0, 32'h20,     1); // WB x5 bypass
    vecs[3]  = mk(1, 1, 0, 1,0, 5, 1,1, 0,0, 0, 0,   0,0,0, 32'h0,      1); // lw x5
    vecs[4]  = mk(1, 2, 3, 1,1, 7, 1,0, 0,0, 0, 0,   0,0,0, 32'h20,     1); // independent add
    vecs[5]  = mk(0, 0, 0, 0,0, 0, 0,0, 0,0, 0, 0,   0,0,0, 32'h20,     1);
    vecs[6]  = mk(0, 0, 0, 0,0, 0, 0,0, 0,0, 1, 5,   0,0,0, 32'h20,     1); // WB x5
    vecs[7]  = mk(1, 1, 0, 1,0, 0, 1,1, 0,0, 0, 0,   0,0,0, 32'h0,      1); // lw x0
    vecs[8]  = mk(1, 0, 0, 1,1, 1, 1,0, 0,0, 0, 0,   0,0,0, 32'h0,      1); // use x0
    vecs[9]  = mk(1, 1, 0, 1,0, 9, 1,1, 0,0, 0, 0,   0,0,0, 32'h0,      1); // lw x9
    vecs[10] = mk(1, 2, 9, 1,1,10, 1,0, 0,0, 1, 9,   0,0,0, 32'h200,    1); // rs2 x9 with WB x9
    vecs[11] = mk(0, 0, 0, 0,0, 0, 0,0, 0,0, 0, 0,   0,0,0, 32'h0,      1);
    vecs[12] = mk(1, 1, 0, 1,0,12, 1,1, 0,0, 0, 0,   0,0,0, 32'h0,      1); // lw x12
    vecs[13] = mk(1, 1, 0, 1,0,12, 1,1, 0,0, 1,12,   0,0,0, 32'h1000,   1); // lw x12 + WB x12
    vecs[14] = mk(1,12, 2, 1,1,13, 1,0, 0,0, 0, 0,   1,1,0, 32'h1000,   1); // set won: hazard
    vecs[15] = mk(1,12, 2, 1,1,13, 1,0, 1,0, 0, 0,   0,1,1, 32'h1000,   2); // flush in HAZ_STALL
    vecs[16] = mk(1, 3,12, 1,1,13, 1,0, 0,0, 0, 0,   1,1,0, 32'h1000,   2); // bit kept, rs2 hazard
    vecs[17] = mk(1, 3,12, 1,1,13, 1,0, 0,0, 1,12,   0,0,0, 32'h1000,   3); // WB x12 bypass
    vecs[18] = mk(0, 0, 0, 0,0, 0, 0,0, 0,0, 0, 0,   0,0,0, 32'h0,      3);

    do_reset();
    #3;
    chk_all("reset", 0, 0, 0, 32'h0, 16'h0);
    tick();

    // Directed vector table.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i]);
      #3;
      $display("vec %0d: spc=%0b bub=%0b flush=%0b mask=%08h cnt=%0d",
               i, bus.stall_pc, bus.bubble_idex, bus.flush_ifid,
               bus.pending_mask, bus.stall_count);
      chk_all($sformatf("vec%0d", i), vecs[i].e_spc, vecs[i].e_bub,
              vecs[i].e_fl, vecs[i].e_mask, vecs[i].e_cnt);
      tick();
    end

    // Memory wait: three busy cycles freeze without a bubble.
    x = idle();
    x.busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(x);
      #3;
      chk_all($sformatf("memwait%0d", i), 1, 0, 0, 32'h0, 16'(3 + i));
      tick();
    end
    drive(idle());
    #3;
    chk_all("memwait_exit", 0, 0, 0, 32'h0, 16'd6);
    tick();

    // Leaving MEM_WAIT re-evaluates a pending load-use hazard that cycle.
    drive(mk(1,1,0,1,0,4,1,1,0,0,0,0, 0,0,0,0,0)); // lw x4
    #3;
    chk("mw_lw.stall_pc", 32'(bus.stall_pc), 32'd0);
    tick();
    x = mk(1,4,0,1,0,6,1,0,0,1,0,0, 0,0,0,0,0);     // add x6,x4 with mem busy
    for (int i = 0; i < 2; i++) begin
      drive(x);
      #3;
      chk_all($sformatf("mw_busy%0d", i), 1, 0, 0, 32'h10, 16'(6 + i));
      tick();
    end
    x.busy = 1'b0;
    drive(x);
    #3;
    chk_all("mw_haz", 1, 1, 0, 32'h10, 16'd8);
    tick();
    x.wbw = 1'b1;
    x.wbrd = 5'd4;
    drive(x);
    #3;
    chk_all("mw_wb", 0, 0, 0, 32'h10, 16'd9);
    tick();

    // Reset while in MEM_WAIT with a load pending.
    drive(mk(1,1,0,1,0,8,1,1,0,0,0,0, 0,0,0,0,0));  // lw x8
    tick();
    x = idle();
    x.busy = 1'b1;
    drive(x);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(idle());
    #3;
    chk_all("rst_memwait", 0, 0, 0, 32'h0, 16'h0);
    tick();

    // Randomized traffic against the rule-level model.
    m_pend = '0;
    m_cnt  = 0;
    for (int i = 0; i < 1500; i++) begin
      x.v    = ($urandom_range(0, 3) != 0);
      x.rs1  = 5'($urandom_range(0, 7));
      x.rs2  = 5'($urandom_range(0, 7));
      x.u1   = 1'($urandom_range(0, 1));
      x.u2   = 1'($urandom_range(0, 1));
      x.rd   = 5'($urandom_range(0, 7));
      x.rw   = ($urandom_range(0, 3) != 0);
      x.ld   = ($urandom_range(0, 2) == 0);
      x.br   = ($urandom_range(0, 15) == 0);
      x.busy = ($urandom_range(0, 7) == 0);
      x.wbw  = 1'($urandom_range(0, 1));
      x.wbrd = 5'($urandom_range(0, 7));
      drive(x);
      #3;
      pend_before = m_pend;
      cnt_before  = m_cnt;
      model_step(x, spc, bub, fl);
      chk_all($sformatf("rnd%0d", i), spc, bub, fl, pend_before,
              16'(cnt_before));
      tick();
    end

    // Stall counter saturates at all-ones.
    do_reset();
    x = idle();
    x.busy = 1'b1;
    drive(x);
    repeat (65534) tick();
    #3;
    chk("sat_pre.stall_count", 32'(bus.stall_count), 32'h0000fffe);
    tick();
    repeat (4) tick();
    #3;
    chk("sat.stall_count", 32'(bus.stall_count), 32'h0000ffff);
    chk("sat.stall_pc", 32'(bus.stall_pc), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
